inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 52 +++++
 rtl/inst_fetch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: memory request/response, redirect and decode handshake bundle.
// id_misalign exists only when IFETCH_MISALIGN_CHECK_EN is defined.
interface inst_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
   logic        id_misalign;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output id_valid, id_inst, id_pc, id_misalign,
      input  id_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  id_valid, id_inst, id_pc, id_misalign,
      output id_ready
   );
`else
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output id_valid, id_inst, id_pc,
      input  id_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  id_valid, id_inst, id_pc,
      output id_ready
   );
`endif
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: request FSM, in-order response buffer and redirect drain.
// Macro IFETCH_MISALIGN_CHECK_EN adds a misaligned-redirect NOP entry.
module inst_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   inst_fetch_if.master bus
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [31:0]   inst_mem [BUF_DEPTH];
   logic [31:0]   pc_mem [BUF_DEPTH];

   logic [CW:0]   occ;
   logic [31:0]   tgt;
   logic          req_ok, req_fire;
   logic          rsp_any, rsp_take;
   logic          push, pop, head_v;
   logic          mis_redir, mis_hold, mis_pend;
   logic [31:0]   mis_pc;

   assign tgt      = bus.redirect_pc & 32'hFFFF_FFFC;
   assign occ      = {1'b0, out_q} + {1'b0, cnt_q};
   assign req_ok   = (state_q == RUN) && !mis_hold &&
                     (occ < {1'b0, DEPTH_C});
   assign req_fire = req_ok && bus.imem_req_ready;
   // Beats with nothing in flight are spurious and ignored.
   assign rsp_any  = bus.imem_rsp_valid &&
                     ((out_q != '0) || (drop_q != '0));
   assign rsp_take = bus.imem_rsp_valid &&
                     (drop_q == '0) && (out_q != '0);
   assign head_v   = (cnt_q != '0);
   assign pop      = head_v && bus.id_ready;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      out_d      = out_q;
      drop_d     = drop_q;
      cnt_d      = cnt_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      push       = 1'b0;
      if (bus.redirect_valid) begin
         fetch_pc_d = tgt;
         rsp_pc_d   = tgt;
         drop_d     = drop_q + out_q + CW'(req_fire) - CW'(rsp_any);
         out_d      = '0;
         cnt_d      = '0;
         wptr_d     = '0;
         rptr_d     = '0;
         state_d    = ((drop_d != '0) && !mis_redir) ? DRAIN : RUN;
      end else begin
         push = rsp_take;
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_take) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wptr_d   = wptr_q + AW'(1);
         end
         if (pop) rptr_d = rptr_q + AW'(1);
         if (rsp_any && (drop_q != '0)) drop_d = drop_q - CW'(1);
         out_d = out_q + CW'(req_fire) - CW'(rsp_take);
         cnt_d = cnt_q + CW'(rsp_take) - CW'(pop);
         unique case (state_q)
            IDLE:    state_d = RUN;
            DRAIN:   if (drop_d == '0) state_d = RUN;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
         cnt_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         cnt_q      <= cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wptr_q] <= bus.imem_rsp_data;
         pc_mem[wptr_q]   <= rsp_pc_q;
      end
   end

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic        mis_hold_q, mis_arm_q, mis_pend_q;
   logic [31:0] mis_pc_q;

   assign mis_redir = bus.redirect_valid &&
                      (bus.redirect_pc[1:0] != 2'b00);

   // Arm delays the NOP by one cycle so id_valid drops after redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_hold_q <= 1'b0;
         mis_arm_q  <= 1'b0;
         mis_pend_q <= 1'b0;
         mis_pc_q   <= '0;
      end else if (bus.redirect_valid) begin
         mis_hold_q <= mis_redir;
         mis_arm_q  <= mis_redir;
         mis_pend_q <= 1'b0;
         mis_pc_q   <= bus.redirect_pc;
      end else if (mis_arm_q) begin
         mis_arm_q  <= 1'b0;
         mis_pend_q <= 1'b1;
      end else if (mis_pend_q && bus.id_ready) begin
         mis_pend_q <= 1'b0;
      end
   end

   assign mis_hold        = mis_hold_q;
   assign mis_pend        = mis_pend_q;
   assign mis_pc          = mis_pc_q;
   assign bus.id_misalign = mis_pend_q;
`else
   assign mis_redir = 1'b0;
   assign mis_hold  = 1'b0;
   assign mis_pend  = 1'b0;
   assign mis_pc    = '0;
`endif

   assign bus.imem_req_valid = req_ok;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.id_valid       = head_v | mis_pend;
   assign bus.id_inst = mis_pend ? NOP :
                        head_v   ? inst_mem[rptr_q] : '0;
   assign bus.id_pc   = mis_pend ? mis_pc :
                        head_v   ? pc_mem[rptr_q] : '0;
endmodule
